key_debounce_multi: RTL and testbench
=====================================

Name: key_debounce_multi

Overview:
Parametrised N-channel debouncer for active-low mechanical keys. Each channel has its own synchroniser, debounce counter and 4-state FSM. Each channel produces a clean level, one-cycle press and release pulses, and a press-toggled latch for driving a LED directly. It sits between board push-buttons and user logic, and supersedes the fixed 3-key, single-shared-counter debounce blocks.

Parameters:
N_KEYS, 3, number of independent key channels (1..16)
DB_CYCLES, 1_000_000, consecutive stable clocks needed to accept a level change (20 ms at 50 MHz); must be >= 2
LONG_CYCLES, 50_000_000, clocks held in PRESSED before long_pulse fires (1 s at 50 MHz); must be > DB_CYCLES; used only with LONG_PRESS_EN
CNT_W, 26, per-channel counter width; must hold max(DB_CYCLES, LONG_CYCLES)-1

Ports:
clk  in  1  system clock, 50 MHz, all logic on rising edge
rst_n  in  1  synchronous active-low reset, sampled on clk rising edge
key_n  in  N_KEYS  raw asynchronous key inputs, 0 = pressed
key_state  out  N_KEYS  debounced level, 1 = pressed
press_pulse  out  N_KEYS  1-cycle strobe on accepted press
release_pulse  out  N_KEYS  1-cycle strobe on accepted release
toggle  out  N_KEYS  flips on every press_pulse (LED drive)
long_pulse  out  N_KEYS  1-cycle strobe on long press (tied 0 without LONG_PRESS_EN)
any_press  out  1  OR of press_pulse, same cycle

Behaviour:
- Reset (rst_n=0 at a clk edge): sync flops = 1; FSM = IDLE; counters = 0; every output = 0. Applies mid-debounce or mid-hold; no pulse is generated on reset entry or exit.
- Sync: 2-flop synchroniser per bit. sync_n[i] is key_n[i] delayed 2 clocks.
- FSM per channel:
  - IDLE: sync_n=0 -> DB_PRESS, cnt=0.
  - DB_PRESS: sync_n=1 -> IDLE, cnt=0. Else if cnt==DB_CYCLES-1 -> PRESSED, cnt=0, press_pulse=1. Else cnt+1.
  - PRESSED: sync_n=1 -> DB_RELEASE, cnt=0. Otherwise cnt counts toward long press (see Optional Feature); cnt stops at its terminal value without wrapping.
  - DB_RELEASE: sync_n=0 -> PRESSED, cnt=0, no pulse, no new long press. Else if cnt==DB_CYCLES-1 -> IDLE, cnt=0, release_pulse=1. Else cnt+1.
- key_state=1 in PRESSED and DB_RELEASE, 0 otherwise. It changes in the same cycle as the corresponding pulse.
- All outputs are registered.
- press_pulse rises DB_CYCLES+2 clocks after the first edge that samples key_n low, provided key_n stays low.
- Release latency is symmetric.
- A glitch shorter than DB_CYCLES accepted samples produces no event.
- toggle[i] <= ~toggle[i] in the cycle press_pulse[i] is registered. toggle is visible 1 cycle after press_pulse.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses; none are dropped or serialised.
- any_press is combinational OR of registered press_pulse.

Optional Feature:
Macro: KEY_DEBOUNCE_LONG_PRESS_EN
- Defined: in PRESSED, cnt increments each cycle. When cnt==LONG_CYCLES-1, long_pulse[i]=1 for one cycle, then cnt holds (saturates). Only one long_pulse is generated per press; there is no auto-repeat. Release or a bounce back to PRESSED re-arms it, because cnt is cleared on entry to PRESSED.
- Undefined: long_pulse driven constant 0. The PRESSED counter is not built. Port list is unchanged.

Test Plan:
- N_KEYS=3, DB_CYCLES=4, reset: hold rst_n=0 for 3 clk with key_n=3'b000 -> all outputs 0. Release reset, keys held low -> press_pulse=3'b111 exactly 6 clk after the first post-reset edge, any_press=1 for 1 clk.
- Key0 low for 3 clk then high (bounce) -> no press_pulse, key_state[0] stays 0. Key0 low for 20 clk -> press_pulse[0] 1 cycle at clk 6, key_state[0]=1, toggle[0]=1.
- Key1 pressed then released with 2-clk high glitch during hold -> no release_pulse during the glitch. A final 10-clk high produces release_pulse[1] at clk 6 after the rising edge, key_state[1]=0.
- Three press/release cycles on key2 -> toggle[2] sequence 1,0,1; exactly 3 press_pulse and 3 release_pulse.
- Reset asserted mid DB_PRESS (cnt=2) and mid PRESSED -> next clk all outputs 0, FSM IDLE. No release_pulse emitted.
- With KEY_DEBOUNCE_LONG_PRESS_EN, LONG_CYCLES=10: hold key0 for 30 clk -> single long_pulse[0] 10 clk after press_pulse[0]. Without the macro -> long_pulse=0 throughout.

Source files
------------

// File: rtl/key_debounce_multi.sv
// N-channel debouncer for active-low keys: 2-flop sync, debounce counter and 4-state FSM per channel.
// Define KEY_DEBOUNCE_LONG_PRESS_EN to build the long-press counter and long_pulse_o strobe.
module key_debounce_multi #(
  parameter int N_KEYS      = 3,
  parameter int DB_CYCLES   = 1_000_000,
  parameter int LONG_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [N_KEYS-1:0] key_n_i,
  output logic [N_KEYS-1:0] key_state_o,
  output logic [N_KEYS-1:0] press_pulse_o,
  output logic [N_KEYS-1:0] release_pulse_o,
  output logic [N_KEYS-1:0] toggle_o,
  output logic [N_KEYS-1:0] long_pulse_o,
  output logic              any_press_o
);

  typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_RELEASE} state_e;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`else
  localparam int unused_long_cycles = LONG_CYCLES;
`endif

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             key_state_q;
    logic             toggle_q;

    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        key_state_q <= 1'b0;
        toggle_q    <= 1'b0;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        press_q     <= press_d;
        release_q   <= release_d;
        key_state_q <= (state_d == PRESSED) || (state_d == DB_RELEASE);
        // Flips one cycle after the press strobe is visible.
        toggle_q    <= toggle_q ^ press_q;
      end
    end

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    logic long_q, long_d;
    logic long_done_q, long_done_d;

    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        long_q      <= 1'b0;
        long_done_q <= 1'b0;
      end else begin
        long_q      <= long_d;
        long_done_q <= long_done_d;
      end
    end

    assign long_pulse_o[gi] = long_q;
`else
    assign long_pulse_o[gi] = 1'b0;
`endif

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
      long_d      = 1'b0;
      // Any visit outside PRESSED re-arms the single long-press strobe.
      long_done_d = (state_q == PRESSED) ? long_done_q : 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (!sync2_q[gi]) begin
            state_d = DB_PRESS;
            cnt_d   = '0;
          end
        end
        DB_PRESS: begin
          if (sync2_q[gi]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = PRESSED;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (sync2_q[gi]) begin
            state_d = DB_RELEASE;
            cnt_d   = '0;
          end
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
          else if (cnt_q != LONG_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end else if (!long_done_q) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end
`endif
        end
        DB_RELEASE: begin
          if (!sync2_q[gi]) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d   = IDLE;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign key_state_o[gi]     = key_state_q;
    assign press_pulse_o[gi]   = press_q;
    assign release_pulse_o[gi] = release_q;
    assign toggle_o[gi]        = toggle_q;
  end

  assign any_press_o = |press_pulse_o;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi (N_KEYS=3, DB_CYCLES=4, LONG_CYCLES=10).
`timescale 1ns/1ps
module tb_key_debounce_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] key_n = 3'b000;
  logic [2:0] key_state, press_pulse, release_pulse, toggle, long_pulse;
  logic       any_press;

  key_debounce_multi #(
    .N_KEYS(3), .DB_CYCLES(4), .LONG_CYCLES(10), .CNT_W(8)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .key_n_i(key_n),
    .key_state_o(key_state),
    .press_pulse_o(press_pulse),
    .release_pulse_o(release_pulse),
    .toggle_o(toggle),
    .long_pulse_o(long_pulse),
    .any_press_o(any_press)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] lng;
    logic [2:0] ks;
    logic [2:0] tog;
  } ev_t;

  ev_t sb_q[$];
  ev_t ev;
  int  checks = 0;
  int  passes = 0;
  int  press2_cnt = 0;
  int  rel2_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  task automatic push(input int ofs, input logic [2:0] p, input logic [2:0] r,
                      input logic [2:0] l, input logic [2:0] ks, input logic [2:0] tg);
    ev_t e;
    e.cyc = cyc + ofs; e.press = p; e.rel = r; e.lng = l; e.ks = ks; e.tog = tg;
    sb_q.push_back(e);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_key_state"}, 32'(key_state), 32'd0);
    chk({tag, "_press"}, 32'(press_pulse), 32'd0);
    chk({tag, "_release"}, 32'(release_pulse), 32'd0);
    chk({tag, "_toggle"}, 32'(toggle), 32'd0);
    chk({tag, "_long"}, 32'(long_pulse), 32'd0);
    chk({tag, "_any"}, 32'(any_press), 32'd0);
  endtask

  // Monitor: pops one expected event whenever any strobe is seen.
  always @(negedge clk) begin
    if (press_pulse[2]) press2_cnt++;
    if (release_pulse[2]) rel2_cnt++;
    if (press_pulse != 3'b000 || release_pulse != 3'b000 || long_pulse != 3'b000 || any_press) begin
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_event at cyc %0d: press=%b release=%b long=%b any=%b, expected no event",
                 cyc, press_pulse, release_pulse, long_pulse, any_press);
      end else begin
        ev = sb_q.pop_front();
        $display("event cyc %0d: press=%b release=%b long=%b key_state=%b toggle=%b",
                 cyc, press_pulse, release_pulse, long_pulse, key_state, toggle);
        chk("event_cycle", cyc, ev.cyc);
        chk("press_pulse", 32'(press_pulse), 32'(ev.press));
        chk("release_pulse", 32'(release_pulse), 32'(ev.rel));
        chk("long_pulse", 32'(long_pulse), 32'(ev.lng));
        chk("key_state", 32'(key_state), 32'(ev.ks));
        chk("toggle", 32'(toggle), 32'(ev.tog));
        chk("any_press", 32'(any_press), 32'(|ev.press));
      end
    end else if (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
      checks++;
      $display("FAIL missing_event: expected at cyc %0d, still absent at cyc %0d", sb_q[0].cyc, cyc);
      void'(sb_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [2:0] tog_p [3];
  logic [2:0] tog_r [3];
  int p2, r2;

  initial begin
    tog_p = '{3'b011, 3'b111, 3'b011};
    tog_r = '{3'b111, 3'b011, 3'b111};

    // Reset held with all keys pressed, then all three accepted together.
    rst_n = 1'b0; key_n = 3'b000;
    wait_n(3);
    check_reset("reset");
    rst_n = 1'b1;
    push(7, 3'b111, 3'b000, 3'b000, 3'b111, 3'b000);
    wait_n(10);
    key_n = 3'b111;
    push(7, 3'b000, 3'b111, 3'b000, 3'b000, 3'b111);
    wait_n(12);

    // Clear toggles between scenarios.
    rst_n = 1'b0; wait_n(1); rst_n = 1'b1; wait_n(2);

    // Key0 short bounce: no event.
    key_n = 3'b110; wait_n(3);
    key_n = 3'b111; wait_n(10);
    chk("bounce_key_state0", 32'(key_state[0]), 32'd0);

    // Key0 held 20 clocks.
    key_n = 3'b110;
    push(7, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000);
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    push(17, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001);
`endif
    wait_n(20);
    key_n = 3'b111;
    push(7, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001);
    wait_n(12);

    // Key1 with a 2-clock release glitch during the hold.
    key_n = 3'b101;
    push(7, 3'b010, 3'b000, 3'b000, 3'b010, 3'b001);
    wait_n(12);
    key_n = 3'b111; wait_n(2);
    key_n = 3'b101; wait_n(6);
    key_n = 3'b111;
    push(7, 3'b000, 3'b010, 3'b000, 3'b000, 3'b011);
    wait_n(12);

    // Key2 three press/release cycles.
    p2 = press2_cnt; r2 = rel2_cnt;
    for (int k = 0; k < 3; k++) begin
      key_n = 3'b011;
      push(7, 3'b100, 3'b000, 3'b000, 3'b100, tog_p[k]);
      wait_n(10);
      chk("toggle2_after_press", 32'(toggle[2]), 32'(tog_r[k][2]));
      key_n = 3'b111;
      push(7, 3'b000, 3'b100, 3'b000, 3'b000, tog_r[k]);
      wait_n(10);
    end
    wait_n(2);
    chk("key2_press_count", press2_cnt - p2, 32'd3);
    chk("key2_release_count", rel2_cnt - r2, 32'd3);

    // Reset mid DB_PRESS (cnt=2).
    key_n = 3'b110;
    wait_n(5);
    rst_n = 1'b0; wait_n(1);
    check_reset("reset_db_press");
    rst_n = 1'b1;
    push(7, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000);
    wait_n(10);
    // Reset mid PRESSED, then keys released: no release strobe.
    rst_n = 1'b0; wait_n(1);
    check_reset("reset_pressed");
    key_n = 3'b111; rst_n = 1'b1;
    wait_n(12);

    // Key0 held 30 clocks: long strobe only when the feature is built.
    key_n = 3'b110;
    push(7, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000);
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    push(17, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001);
`endif
    wait_n(30);
    key_n = 3'b111;
    push(7, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001);
    wait_n(12);

    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
